uart_rx_cfg: RTL

Parametrised successor to the fixed 8N1 UART receiver in the serial I/O path. It supports configurable data width, parity mode and stop-bit count. It reports parity errors, framing errors and line breaks alongside each received word. Received words are delivered to the downstream word consumer (command decoder / FIFO) as a one-cycle valid strobe with the data and status flags.

---
 rtl/uart_rx_cfg.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver (5..9 data bits, none/odd/even
// parity, 1 or 2 stop bits) with parity, framing and break reporting.
//
// Output handshake: rx_valid is a one-cycle strobe with no back-pressure;
// rx_data, parity_err, frame_err and break_det are valid in that cycle and
// hold until the next strobe.
//
// state_dbg encoding: 0 IDLE, 1 START, 2 DATA, 3 PARITY, 4 STOP, 5 DONE,
// 6 WAIT_HIGH.
module uart_rx_cfg #(
    parameter int CLKS_PER_BIT = 104,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 serial_data,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic [2:0]           state_dbg
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int HALF  = (CLKS_PER_BIT - 1) / 2;
    localparam int IDX_W = 4;
    localparam logic ODD_MODE = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_DONE      = 3'd5,
        S_WAIT_HIGH = 3'd6
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_sync1;
    logic                 r_sync2;
    logic [CNT_W-1:0]     r_cnt;
    logic [IDX_W-1:0]     r_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_bit;
    logic                 r_ferr;
    logic                 r_any_high;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid;
    logic                 r_parity_err;
    logic                 r_frame_err;
    logic                 r_break_det;

    logic                 w_rx_s;
    logic                 w_tick;
    logic                 w_half;
    logic                 w_last_data;
    logic                 w_last_stop;
    logic                 w_fe;
    logic                 w_brk;
    logic                 w_pe;

    assign w_rx_s      = r_sync2;
    assign w_tick      = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));
    // START is left on its HALF-th cycle so that the first data sample
    // lands 3 + HALF + CLKS_PER_BIT cycles after the line falls.
    assign w_half      = (r_cnt == CNT_W'(HALF - 1));
    assign w_last_data = (r_idx == IDX_W'(DATA_BITS - 1));
    assign w_last_stop = (r_idx == IDX_W'(STOP_BITS - 1));

    // Final status, folding in the stop sample taken this cycle.
    assign w_fe  = r_ferr | ~w_rx_s;
    assign w_brk = w_fe & ~(r_any_high | w_rx_s);
    assign w_pe  = (PARITY != 0) && (((^r_shift) ^ r_par_bit) != ODD_MODE);

    assign rx_data    = r_rx_data;
    assign rx_valid   = r_rx_valid;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign break_det  = r_break_det;
    assign state_dbg  = r_state;

    // Two-flop synchronizer on the asynchronous line; presets to idle-high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= serial_data;
            r_sync2 <= r_sync1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; unknown encodings fall back to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (!w_rx_s) w_state_nxt = S_START;
            end
            S_START: begin
                if (w_half) w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (w_tick && w_last_data)
                    w_state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                if (w_tick) w_state_nxt = S_STOP;
            end
            S_STOP: begin
                if (w_tick && w_last_stop) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_state_nxt = r_frame_err ? S_WAIT_HIGH : S_IDLE;
            end
            S_WAIT_HIGH: begin
                if (w_rx_s) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Bit timing, sampling and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_shift      <= '0;
            r_par_bit    <= 1'b0;
            r_ferr       <= 1'b0;
            r_any_high   <= 1'b0;
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_break_det  <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            case (r_state)
                S_START: begin
                    r_cnt <= w_half ? '0 : r_cnt + 1'b1;
                end
                S_DATA: begin
                    if (w_tick) begin
                        r_cnt <= '0;
                        for (int i = 0; i < DATA_BITS; i++) begin
                            if (r_idx == IDX_W'(i)) r_shift[i] <= w_rx_s;
                        end
                        r_any_high <= r_any_high | w_rx_s;
                        r_idx      <= w_last_data ? '0 : r_idx + 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (w_tick) begin
                        r_cnt      <= '0;
                        r_par_bit  <= w_rx_s;
                        r_any_high <= r_any_high | w_rx_s;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_tick) begin
                        r_cnt      <= '0;
                        r_ferr     <= w_fe;
                        r_any_high <= r_any_high | w_rx_s;
                        if (w_last_stop) begin
                            r_idx        <= '0;
                            r_rx_valid   <= 1'b1;
                            r_rx_data    <= r_shift;
                            r_parity_err <= w_pe;
                            r_frame_err  <= w_fe;
                            r_break_det  <= w_brk;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    // IDLE, DONE, WAIT_HIGH: clear per-frame state.
                    r_cnt      <= '0;
                    r_idx      <= '0;
                    r_ferr     <= 1'b0;
                    r_any_high <= 1'b0;
                end
            endcase
        end
    end

endmodule
